delayed_branch_tracker: RTL
===========================

DELAYED_BRANCH_TRACKER -- requirements
Module: delayed_branch_tracker

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning issue lanes tracked (p0 older than p1); only 2 is supported.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port advance  in  1  pipeline advances this edge (same qualifier as fetch-next).
REQ-005 SHALL have port halted  in  1  system halted; freezes capture and firing.
REQ-006 SHALL have ports p0_dly_in, p1_dly_in  in  16 each  delayed branch word: [15:8] head, [7:0] absolute destination.
REQ-007 SHALL have ports p0_cond_in, p1_cond_in  in  3 each  delayed condition code.
REQ-008 SHALL have ports p0_s1_valid, p1_s1_valid  in  1 each  lane holds a valid branch at S1 (already reset_S1/IR0-invalid qualified).
REQ-009 SHALL have ports N, V, Z  in  1 each  flags valid for the S3 bundle.
REQ-010 SHALL have ports p0_do_delayed_B, p1_do_delayed_B  out  1 each  replay the lane's delayed branch.
REQ-011 SHALL have ports p0_IR_inject, p1_IR_inject  out  16 each  word to drive into the branch unit IR when do is high.
REQ-012 SHALL have port flush  out  1  clear all younger instructions at S1/S2.

Function
REQ-013 SHALL keep per lane two stages S2, S3: {valid, word[15:0], cond[2:0]}.
REQ-014 SHALL, on an edge with advance=1, load S2 from S1 inputs (valid = s1_valid AND cond != NV) and S3 from S2.
REQ-015 SHALL hold all S2/S3 state and all outputs on edges with advance=0.
REQ-016 SHALL evaluate S3 conditions: NV=0, AL=1, EQ=Z, NE=~Z, LT=N^V, LE=Z|(N^V), GT=~Z&~(N^V), GE=~(N^V); encodings 0..7 in that order.
REQ-017 SHALL fire lane k on an advance edge when S3 lane k is valid, its condition is true, and no older lane fires.
REQ-018 SHALL give p0 priority: if p0 fires, p1 SHALL NOT fire on that edge, even if its condition is true.
REQ-019 SHALL, on a firing edge, register do=1 for the fired lane only, IR_inject=that lane's S3 word, flush=1.
REQ-020 SHALL, on a firing edge, clear every S2 and S3 valid bit and not capture S1 inputs.
REQ-021 SHALL, on a non-firing advance edge, register all do bits, flush, and IR_inject outputs to 0.
REQ-022 SHALL keep do/flush registered for exactly one advance period (1-cycle pulse when advance stays 1).
REQ-023 SHALL guarantee p0_do_delayed_B and p1_do_delayed_B are never both 1.
REQ-024 SHALL treat a true S3 condition with an invalid entry as no fire.
REQ-025 SHALL, while halted=1, not fire, not capture, and drive do/flush low; state is retained.
REQ-026 SHALL pass the head byte through unmodified (8'b001_00_111 replays as an immediate halt).

Reset
REQ-027 SHALL, on rst low, asynchronously clear all valid bits, do outputs, flush, and IR_inject to 0.
REQ-028 SHALL, on reset mid-firing, never emit a residual do/flush pulse after rst deasserts.

Structure
REQ-029 SHALL take condition codes NV..GE and head constants HEAD_B=8'b001_00_000 and HEAD_HALT=8'b001_00_111 from the shared branch package.
REQ-030 SHALL implement condition evaluation as one combinational sub-module cond_eval (cond, N, V, Z -> met), instantiated once per lane.

Verification
REQ-031 SHALL verify: p0 captures {0x2014, EQ} valid, advance held 1, Z=1 at S3 -> p0_do=1 and IR_inject=0x2014 on the 2nd edge, flush=1, 1 cycle.
REQ-032 SHALL verify: same stimulus with Z=0 -> no do and no flush; the entry drops out after S3.
REQ-033 SHALL verify: p0 {0x2030, AL} and p1 {0x2040, AL} in the same bundle -> only p0 fires; p1 is discarded, and a following bundle in S2 is flushed.
REQ-034 SHALL verify: capture {0x2050, LT}, advance=0 for 3 cycles between stages, N=1, V=0 -> fires on the 2nd advance edge; outputs hold during the stall.
REQ-035 SHALL verify: p1 {0x2709, AL} (halt head) -> p1_IR_inject=0x2709, p1_do=1; halted=1 next cycle -> no further fires.
REQ-036 SHALL verify: rst low while S3 is valid with a true condition -> all outputs 0 immediately; no fire after release.

Source files
------------

// File: rtl/delayed_branch_tracker_pkg.sv
// Shared branch definitions: delayed-branch condition codes, branch head bytes
// and the per-lane pipeline entry used by the delayed branch tracker.
package delayed_branch_tracker_pkg;

  typedef enum logic [2:0] {
    NV = 3'd0,
    AL = 3'd1,
    EQ = 3'd2,
    NE = 3'd3,
    LT = 3'd4,
    LE = 3'd5,
    GT = 3'd6,
    GE = 3'd7
  } cond_e;

  localparam logic [7:0] HEAD_B    = 8'b001_00_000;
  localparam logic [7:0] HEAD_HALT = 8'b001_00_111;
  localparam int         WORD_W    = 16;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] word;
    cond_e             cond;
  } stage_t;

  // A never-taken branch is dropped at capture so it can never reach S3.
  function automatic stage_t make_stage(input logic              valid,
                                        input logic [WORD_W-1:0] word,
                                        input logic [2:0]        cond);
    stage_t s;
    s.valid = valid && (cond != NV);
    s.word  = word;
    s.cond  = cond_e'(cond);
    return s;
  endfunction

endpackage

// File: rtl/delayed_branch_tracker_cond_eval.sv
// Combinational evaluation of one delayed branch condition against the
// N/V/Z flags that belong to the S3 bundle.
module cond_eval
  import delayed_branch_tracker_pkg::*;
(
  input  cond_e cond,
  input  logic  n,
  input  logic  v,
  input  logic  z,
  output logic  met
);

  logic less;

  assign less = n ^ v;

  always_comb begin
    met = 1'b0;
    case (cond)
      NV:      met = 1'b0;
      AL:      met = 1'b1;
      EQ:      met = z;
      NE:      met = ~z;
      LT:      met = less;
      LE:      met = z | less;
      GT:      met = ~z & ~less;
      GE:      met = ~less;
      default: met = 1'b0;
    endcase
  end

endmodule

// File: rtl/delayed_branch_tracker.sv
// Tracks delayed branches from two issue lanes through S2/S3 and replays the
// oldest taken one into the branch unit, flushing the younger work behind it.
module delayed_branch_tracker
  import delayed_branch_tracker_pkg::*;
#(
  parameter int LANES = 2
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        halted,
  input  logic [15:0] p0_dly_in,
  input  logic [15:0] p1_dly_in,
  input  logic [2:0]  p0_cond_in,
  input  logic [2:0]  p1_cond_in,
  input  logic        p0_s1_valid,
  input  logic        p1_s1_valid,
  input  logic        N,
  input  logic        V,
  input  logic        Z,
  output logic        p0_do_delayed_B,
  output logic        p1_do_delayed_B,
  output logic [15:0] p0_IR_inject,
  output logic [15:0] p1_IR_inject,
  output logic        flush
);

  stage_t s1   [LANES];
  stage_t s2_q [LANES];
  stage_t s3_q [LANES];

  logic [LANES-1:0] met;
  logic             fire_p0;
  logic             fire_p1;
  logic             any_fire;
  logic             step;

  always_comb begin
    s1[0] = make_stage(p0_s1_valid, p0_dly_in, p0_cond_in);
    s1[1] = make_stage(p1_s1_valid, p1_dly_in, p1_cond_in);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cond_eval u_cond_eval (
      .cond (s3_q[k].cond),
      .n    (N),
      .v    (V),
      .z    (Z),
      .met  (met[k])
    );
  end

  // p0 is the older lane, so a taken p0 suppresses p1 even when p1 is taken too.
  always_comb begin
    fire_p0  = s3_q[0].valid && met[0];
    fire_p1  = s3_q[1].valid && met[1] && !fire_p0;
    any_fire = fire_p0 || fire_p1;
    step     = advance && !halted;
  end

  // A firing edge squashes everything younger and refuses the S1 bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LANES; k++) begin
        s2_q[k] <= '0;
        s3_q[k] <= '0;
      end
    end else if (step) begin
      if (any_fire) begin
        for (int k = 0; k < LANES; k++) begin
          s2_q[k].valid <= 1'b0;
          s3_q[k].valid <= 1'b0;
        end
      end else begin
        for (int k = 0; k < LANES; k++) begin
          s2_q[k] <= s1[k];
          s3_q[k] <= s2_q[k];
        end
      end
    end
  end

  // Outputs only change on advance edges, so a pulse lasts one advance period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_do_delayed_B <= 1'b0;
      p1_do_delayed_B <= 1'b0;
      flush           <= 1'b0;
      p0_IR_inject    <= '0;
      p1_IR_inject    <= '0;
    end else if (halted) begin
      p0_do_delayed_B <= 1'b0;
      p1_do_delayed_B <= 1'b0;
      flush           <= 1'b0;
      p0_IR_inject    <= '0;
      p1_IR_inject    <= '0;
    end else if (advance) begin
      p0_do_delayed_B <= fire_p0;
      p1_do_delayed_B <= fire_p1;
      flush           <= any_fire;
      p0_IR_inject    <= fire_p0 ? s3_q[0].word : '0;
      p1_IR_inject    <= fire_p1 ? s3_q[1].word : '0;
    end
  end

endmodule
